imm_extract_stage: RTL and testbench

//  Registered, parametrised immediate-extraction stage for the decode pipeline.

---
 rtl/imm_pkg.sv | 47 ++++
 rtl/imm_extract_stage_skid.sv | 76 +++++++
 rtl/imm_extract_stage.sv | 62 ++++++
 tb/tb_imm_extract_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate formats and extraction helper for the decode pipeline.
// imm_calc always builds a 64-bit value; callers keep the low XLEN bits.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'd0,
      IMM_S   = 3'd1,
      IMM_B   = 3'd2,
      IMM_J   = 3'd3,
      IMM_U   = 3'd4,
      IMM_Z   = 3'd5,
      IMM_SH  = 3'd6,
      IMM_RSV = 3'd7
   } imm_type_e;

   typedef struct packed {
      logic        err;
      logic [63:0] imm;
   } imm_res_t;

   // Sign-extended formats are built at 64 bits; the low 32 bits are
   // identical to a native 32-bit extension, so XLEN=32 just truncates.
   // Only the shift amount differs by width (5 vs 6 bits).
   function automatic imm_res_t imm_calc(
      input logic [31:0] inst,
      input imm_type_e   ty,
      input logic        xlen64
   );
      imm_res_t r;
      r.err = 1'b0;
      r.imm = '0;
      unique case (ty)
         IMM_I:   r.imm = {{52{inst[31]}}, inst[31:20]};
         IMM_S:   r.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   r.imm = {{51{inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
         IMM_J:   r.imm = {{43{inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
         IMM_U:   r.imm = {{32{inst[31]}}, inst[31:12], 12'h000};
         IMM_Z:   r.imm = {59'd0, inst[19:15]};
         IMM_SH:  r.imm = {58'd0, xlen64 & inst[25], inst[24:20]};
         IMM_RSV: r.err = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imm_extract_stage_skid.sv
// Generic 2-entry valid/ready skid buffer (output reg + one skid entry).
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module imm_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         ov_q, ov_d;
   logic         sv_q, sv_d;
   logic         rdy_q, rdy_d;
   logic [W-1:0] od_q, od_d;
   logic [W-1:0] sd_q, sd_d;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & rdy_q;
   assign out_fire = ov_q & out_ready;

   always_comb begin
      ov_d = ov_q;
      od_d = od_q;
      sv_d = sv_q;
      sd_d = sd_q;
      if (flush) begin
         ov_d = 1'b0;
         sv_d = 1'b0;
      end else if (!ov_q || out_fire) begin
         // Output slot frees up: skid entry (older) goes first.
         if (sv_q) begin
            ov_d = 1'b1;
            od_d = sd_q;
            sv_d = in_fire;
            if (in_fire) sd_d = in_data;
         end else begin
            ov_d = in_fire;
            if (in_fire) od_d = in_data;
         end
      end else if (in_fire) begin
         sv_d = 1'b1;
         sd_d = in_data;
      end
      // Ready is registered from next skid state: no out_ready path.
      rdy_d = !sv_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q  <= 1'b0;
         sv_q  <= 1'b0;
         rdy_q <= 1'b0;
         od_q  <= '0;
         sd_q  <= '0;
      end else begin
         ov_q  <= ov_d;
         sv_q  <= sv_d;
         rdy_q <= rdy_d;
         od_q  <= od_d;
         sd_q  <= sd_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;

endmodule

// File: rtl/imm_extract_stage.sv
// Registered immediate-extraction stage with skid buffer and flush.
// Ports: clk, rst_n, flush, in_* (valid/ready/inst/type/tag), out_* (valid/ready/imm/err/tag).
module imm_extract_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_type,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W = 1 + XLEN + TAG_W;

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_extract_stage: XLEN must be 32 or 64");
      end
   endgenerate

   imm_res_t       res;
   logic [W-1:0]   in_data;
   logic [W-1:0]   out_data;

   assign res     = imm_calc(in_inst, imm_type_e'(in_type), XLEN == 64);
   assign in_data = {res.err, res.imm[XLEN-1:0], in_tag};

   generate
      if (XLEN < 64) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^res.imm[63:XLEN];
      end
   endgenerate

   imm_skid_buf #(
      .W(W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign {out_err, out_imm, out_tag} = out_data;

endmodule

// File: tb/tb_imm_extract_stage.sv
// Randomised + directed bench for imm_extract_stage at XLEN 32 and 64.
// Reference: queue of accepted entries, immediates by plain arithmetic.
module tb_imm_extract_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [2:0]  in_type = '0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        rdy32, rdy64, ov32, ov64, err32, err64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [4:0]  tag32, tag64;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  ty;
      logic [4:0]  tag;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   imm_extract_stage #(.XLEN(32), .TAG_W(5)) u32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32),
      .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
      .out_valid(ov32), .out_ready(out_ready),
      .out_imm(imm32), .out_err(err32), .out_tag(tag32)
   );

   imm_extract_stage #(.XLEN(64), .TAG_W(5)) u64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64),
      .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
      .out_valid(ov64), .out_ready(out_ready),
      .out_imm(imm64), .out_err(err64), .out_tag(tag64)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Immediate value from the format's bit weights; the sign bit
   // carries a negative weight.
   function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                           input logic [2:0] t,
                                           input int xlen);
      longint v;
      longint s;
      s = i[31];
      v = 0;
      case (t)
         3'd0: begin v = i[30:20]; v = v - s * 2048; end
         3'd1: begin v = i[30:25]; v = v * 32 + i[11:7] - s * 2048; end
         3'd2: begin
            v = i[7];
            v = v * 2048 + i[30:25] * 32 + i[11:8] * 2 - s * 4096;
         end
         3'd3: begin
            v = i[19:12];
            v = v * 4096 + i[20] * 2048 + i[30:21] * 2 - s * 1048576;
         end
         3'd4: begin v = i[30:12]; v = v * 4096 - s * 64'h8000_0000; end
         3'd5: v = i[19:15];
         3'd6: v = (xlen == 32) ? i[24:20] : i[25:20];
         default: v = 0;
      endcase
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic cmp_model();
      ent_t e;
      chk("in_ready32", rdy32, q.size() < 2);
      chk("in_ready64", rdy64, q.size() < 2);
      chk("out_valid32", ov32, q.size() > 0);
      chk("out_valid64", ov64, q.size() > 0);
      if (q.size() > 0) begin
         e = q[0];
         chk("imm32", imm32, ref_imm(e.inst, e.ty, 32));
         chk("imm64", imm64, ref_imm(e.inst, e.ty, 64));
         chk("err32", err32, e.ty == 3'd7);
         chk("err64", err64, e.ty == 3'd7);
         chk("tag32", tag32, e.tag);
         chk("tag64", tag64, e.tag);
      end
   endtask

   // Called at a negedge: drive, advance model, check at next negedge.
   task automatic cyc(input logic v, input logic [31:0] inst,
                      input logic [2:0] ty, input logic [4:0] tg,
                      input logic ordy, input logic fl);
      ent_t e;
      bit   push;
      bit   pop;
      in_valid  = v;
      in_inst   = inst;
      in_type   = ty;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      if (fl) begin
         q.delete();
      end else begin
         push = v && (q.size() < 2);
         pop  = ordy && (q.size() > 0);
         if (pop) void'(q.pop_front());
         if (push) begin
            e.inst = inst;
            e.ty   = ty;
            e.tag  = tg;
            q.push_back(e);
         end
      end
      @(negedge clk);
      cmp_model();
   endtask

   task automatic chk_zero_out(input string tag);
      chk({tag, "_ov"}, {ov32, ov64}, 2'b00);
      chk({tag, "_rdy"}, {rdy32, rdy64}, 2'b00);
      chk({tag, "_imm32"}, imm32, 64'd0);
      chk({tag, "_imm64"}, imm64, 64'd0);
      chk({tag, "_err"}, {err32, err64}, 2'b00);
      chk({tag, "_tag"}, {tag32, tag64}, 10'd0);
   endtask

   initial begin
      @(negedge clk);
      chk_zero_out("reset");
      rst_n = 1'b1;
      cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
      chk("rdy_after_rst", rdy32, 1'b1);

      // Format examples.
      cyc(1, 32'hFFF00093, 3'd0, 5'd7, 1, 0);
      chk("t1_imm", imm32, 64'hFFFF_FFFF);
      chk("t1_tag", tag32, 5'd7);
      cyc(1, 32'hFE000EE3, 3'd2, 5'd8, 1, 0);
      chk("t2_b", imm32, 64'hFFFF_FFFC);
      cyc(1, 32'hFFDFF0EF, 3'd3, 5'd9, 1, 0);
      chk("t2_j", imm32, 64'hFFFF_FFFC);
      cyc(1, 32'h800000B7, 3'd4, 5'd10, 1, 0);
      chk("t3_u", imm64, 64'hFFFF_FFFF_8000_0000);
      cyc(1, 32'h03F09093, 3'd6, 5'd11, 1, 0);
      chk("t3_sh64", imm64, 64'h3F);
      chk("t3_sh32", imm32, 64'h1F);
      cyc(1, 32'h000FD073, 3'd5, 5'd12, 1, 0);
      chk("t3_z", imm64, 64'h1F);
      cyc(1, 32'hFFFFFFFF, 3'd7, 5'd13, 1, 0);
      chk("t5_err", err64, 1'b1);
      chk("t5_imm", imm64, 64'd0);
      cyc(1, 32'h00500093, 3'd0, 5'd14, 1, 0);
      chk("t5_next", {err32, tag32}, {1'b0, 5'd14});
      cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);

      // Backpressure and skid.
      cyc(1, 32'h12345013, 3'd0, 5'd1, 0, 0);
      cyc(1, 32'h80000037, 3'd4, 5'd2, 0, 0);
      chk("t4_rdy0", rdy32, 1'b0);
      cyc(1, 32'hABCDE0EF, 3'd3, 5'd3, 0, 0);
      chk("t4_hold1", tag32, 5'd1);
      cyc(1, 32'hABCDE0EF, 3'd3, 5'd3, 1, 0);
      chk("t4_tag2", tag32, 5'd2);
      cyc(1, 32'hABCDE0EF, 3'd3, 5'd3, 1, 0);
      chk("t4_tag3", tag32, 5'd3);
      cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);

      // Flush with both entries full and an input offered.
      cyc(1, 32'h00100093, 3'd0, 5'd20, 0, 0);
      cyc(1, 32'h00200093, 3'd0, 5'd21, 0, 0);
      cyc(1, 32'h00300093, 3'd0, 5'd22, 0, 1);
      chk("t6_ov", ov64, 1'b0);
      chk("t6_rdy", rdy64, 1'b1);
      cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);
      chk("t6_gone", ov32, 1'b0);

      // Asynchronous reset mid-stream.
      cyc(1, 32'hFFF00093, 3'd0, 5'd23, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk_zero_out("async_rst");
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 32'h0, 3'd0, 5'd0, 1, 0);

      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 99) < 70, $urandom(),
             3'($urandom_range(0, 7)), 5'($urandom()),
             $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
